// File: rtl/systolic_job_arbiter_if.sv
// -----------------------------------------------------------------------------
// systolic_job_arbiter_if
//
// Purpose: bundles the requester-side job handshake and the systolic
// controller start/done pair that pass through systolic_job_arbiter.
//
// Signals:
//   req           requester -> arbiter   per-requester job request
//   req_addr      requester -> arbiter   flattened per-requester base addresses
//   gnt           arbiter -> requester   one-hot current owner
//   owner_id      arbiter -> requester   index of the current or last owner
//   busy          arbiter -> requester   arbiter is not idle
//   job_done      arbiter -> requester   one-cycle completion pulse, owner bit
//   job_err       arbiter -> requester   watchdog timeout flag
//   tpu_start     arbiter -> controller  one-cycle start pulse
//   tpu_base_addr arbiter -> controller  latched base address of the owner
//   tpu_done      controller -> arbiter  done pulse
//
// Modports:
//   master  environment side (requesters + systolic controller)
//   slave   the arbiter itself
// -----------------------------------------------------------------------------
interface systolic_job_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [ID_W-1:0]           owner_id;
  logic                      busy;
  logic                      tpu_start;
  logic [ADDR_W-1:0]         tpu_base_addr;
  logic                      tpu_done;
  logic [NUM_REQ-1:0]        job_done;
  logic                      job_err;

  modport master (
    output req, req_addr, tpu_done,
    input  gnt, owner_id, busy, tpu_start, tpu_base_addr, job_done, job_err
  );

  modport slave (
    input  req, req_addr, tpu_done,
    output gnt, owner_id, busy, tpu_start, tpu_base_addr, job_done, job_err
  );
endinterface

// File: rtl/systolic_job_arbiter.sv
// -----------------------------------------------------------------------------
// systolic_job_arbiter
//
// Purpose: shares one systolic array controller among NUM_REQ job requesters.
// A round-robin pick chooses the next requester, the arbiter fires a one-cycle
// tpu_start with that requester's base address, waits for tpu_done and then
// returns a one-cycle job_done to the owner. All outputs are registered.
//
// Parameters:
//   NUM_REQ  number of requesters (power of two, 2..8)
//   ADDR_W   width of each requester's base address
//   TIMEOUT  watchdog limit in RUN cycles (watchdog build only)
//
// Ports:
//   clk    clock
//   srstn  asynchronous active-low reset
//   bus    systolic_job_arbiter_if.slave (req/req_addr/gnt/owner_id/busy/
//          tpu_start/tpu_base_addr/tpu_done/job_done/job_err)
//
// Optional feature:
//   SYS_ARB_TIMEOUT_EN  when defined, a RUN-state watchdog forces completion
//                       with job_err after TIMEOUT cycles without tpu_done.
//                       When undefined, job_err stays 0 and RUN waits forever.
// -----------------------------------------------------------------------------
module systolic_job_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     srstn,
  systolic_job_arbiter_if.slave    bus
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  // Elaboration-time guard on the parameter ranges the pointer arithmetic
  // relies on (wrap-around by truncation needs a power-of-two NUM_REQ).
  if (NUM_REQ < 2 || NUM_REQ > 8 || (NUM_REQ & (NUM_REQ - 1)) != 0 ||
      TIMEOUT < 2) begin : g_bad_params
    $error("systolic_job_arbiter: illegal NUM_REQ/TIMEOUT parameter");
  end

  logic [1:0]         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    owner_id_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] job_done_q;
  logic               busy_q;
  logic               tpu_start_q;
  logic               job_err_q;
  logic [ADDR_W-1:0]  base_addr_q;

  logic               pick_valid;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W-1:0]    cand;
  logic [ADDR_W-1:0]  pick_addr;
  logic               wdog_hit;

  // Round-robin pick: scan rr_ptr, rr_ptr+1, ... with wrap by truncation.
  // The loop runs from the farthest candidate down so the nearest requester
  // to rr_ptr is the last (and winning) assignment.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = rr_ptr;
    cand       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = rr_ptr + ID_W'(k);
      if (bus.req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  assign pick_addr = bus.req_addr[pick_id*ADDR_W +: ADDR_W];

`ifdef SYS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] wdog_cnt;

  assign wdog_hit = (wdog_cnt == CNT_W'(TIMEOUT - 1));

  // Watchdog: cleared while in START so it reads 0 on the first RUN cycle,
  // then counts RUN cycles. Reaching TIMEOUT-1 means TIMEOUT RUN cycles have
  // elapsed by the time the FSM lands in DONE.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      wdog_cnt <= '0;
    end else if (state == ST_START) begin
      wdog_cnt <= '0;
    end else if (state == ST_RUN && !wdog_hit) begin
      wdog_cnt <= wdog_cnt + CNT_W'(1);
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  // Main job FSM. tpu_start, job_done and job_err default low each cycle so
  // they can only ever be one-cycle pulses. gnt/busy/base address are held
  // from START through DONE; owner_id keeps the last owner after the job.
  // tpu_done outside RUN is simply never looked at.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      owner_id_q  <= '0;
      gnt_q       <= '0;
      job_done_q  <= '0;
      busy_q      <= 1'b0;
      tpu_start_q <= 1'b0;
      job_err_q   <= 1'b0;
      base_addr_q <= '0;
    end else begin
      tpu_start_q <= 1'b0;
      job_done_q  <= '0;
      job_err_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state       <= ST_START;
            owner_id_q  <= pick_id;
            gnt_q       <= ONE_HOT_0 << pick_id;
            base_addr_q <= pick_addr;
            tpu_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_START: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          // A real tpu_done wins over a simultaneous watchdog expiry.
          if (bus.tpu_done) begin
            state      <= ST_DONE;
            job_done_q <= ONE_HOT_0 << owner_id_q;
          end else if (wdog_hit) begin
            state      <= ST_DONE;
            job_done_q <= ONE_HOT_0 << owner_id_q;
            job_err_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          gnt_q  <= '0;
          busy_q <= 1'b0;
          rr_ptr <= owner_id_q + ID_W'(1);
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.owner_id      = owner_id_q;
  assign bus.busy          = busy_q;
  assign bus.tpu_start     = tpu_start_q;
  assign bus.tpu_base_addr = base_addr_q;
  assign bus.job_done      = job_done_q;
  assign bus.job_err       = job_err_q;

endmodule

// File: tb/tb_systolic_job_arbiter.sv
// -----------------------------------------------------------------------------
// tb_systolic_job_arbiter
//
// Self-checking bench for systolic_job_arbiter. A job-level reference model
// (round-robin pointer, address table, per-requester wait counts) predicts
// each grant; the bench plays both the requesters and the systolic
// controller. Directed scenarios come first, then randomized jobs.
// -----------------------------------------------------------------------------
module tb_systolic_job_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic srstn;

  always #5 clk = ~clk;

  systolic_job_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) bus ();

  systolic_job_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .srstn(srstn),
    .bus  (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  int                modelPtr;
  logic [ADDR_W-1:0] addrTab [NUM_REQ];
  int                waitCnt [NUM_REQ];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Spec rule: first requester found scanning from the pointer, modulo NUM_REQ.
  function automatic int rrPick(input logic [NUM_REQ-1:0] mask, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic packAddr();
    for (int i = 0; i < NUM_REQ; i++) bus.req_addr[i*ADDR_W +: ADDR_W] = addrTab[i];
  endtask

  task automatic applyReset();
    srstn        = 1'b0;
    bus.req      = '0;
    bus.tpu_done = 1'b0;
    step();
    step();
    srstn    = 1'b1;
    modelPtr = 0;
    for (int i = 0; i < NUM_REQ; i++) waitCnt[i] = 0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"},      bus.gnt,           0);
    checkOutput({tag, "_owner"},    bus.owner_id,      0);
    checkOutput({tag, "_busy"},     bus.busy,          0);
    checkOutput({tag, "_start"},    bus.tpu_start,     0);
    checkOutput({tag, "_addr"},     bus.tpu_base_addr, 0);
    checkOutput({tag, "_job_done"}, bus.job_done,      0);
    checkOutput({tag, "_job_err"},  bus.job_err,       0);
  endtask

  // Grant bookkeeping for the fairness bound: every requester that was
  // waiting but lost must not lose more than NUM_REQ-1 times in a row.
  task automatic noteGrant(input int owner);
    int worst;
    worst = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i == owner || !bus.req[i]) waitCnt[i] = 0;
      else waitCnt[i]++;
      if (waitCnt[i] > worst) worst = waitCnt[i];
    end
    checkOutput("fairness_ok", (worst <= NUM_REQ - 1), 1);
  endtask

  // One whole job, starting in an IDLE cycle with req already driven.
  // doneDelay = cycles from tpu_start to the tpu_done pulse (>= 2).
  task automatic applyStimulus(input int doneDelay, input bit spurStart,
                               input bit dropInRun, input int expectOwner);
    int                 owner;
    logic [NUM_REQ-1:0] expGnt;
    logic [ADDR_W-1:0]  expAddr;
    owner = rrPick(bus.req, modelPtr);
    if (owner < 0) begin
      checkOutput("job_has_request", 0, 1);
      return;
    end
    expGnt  = '0;
    expGnt[owner] = 1'b1;
    expAddr = addrTab[owner];
    noteGrant(owner);
    step();
    checkOutput("start_pulse", bus.tpu_start,     1);
    checkOutput("start_gnt",   bus.gnt,           expGnt);
    checkOutput("start_owner", bus.owner_id,      owner);
    checkOutput("start_addr",  bus.tpu_base_addr, expAddr);
    checkOutput("start_busy",  bus.busy,          1);
    if (expectOwner >= 0) checkOutput("directed_owner", bus.owner_id, expectOwner);
    if (spurStart) bus.tpu_done = 1'b1;
    for (int c = 1; c <= doneDelay; c++) begin
      step();
      bus.tpu_done = (c == doneDelay);
      if (dropInRun && c == 1) bus.req[owner] = 1'b0;
      checkOutput("run_start_low", bus.tpu_start,     0);
      checkOutput("run_no_done",   bus.job_done,      0);
      checkOutput("run_gnt",       bus.gnt,           expGnt);
      checkOutput("run_addr",      bus.tpu_base_addr, expAddr);
      checkOutput("run_busy",      bus.busy,          1);
    end
    step();
    bus.tpu_done = 1'b0;
    checkOutput("done_pulse", bus.job_done, expGnt);
    checkOutput("done_err",   bus.job_err,  0);
    checkOutput("done_gnt",   bus.gnt,      expGnt);
    checkOutput("done_busy",  bus.busy,     1);
    bus.req[owner] = 1'b0;
    step();
    checkOutput("idle_gnt",      bus.gnt,       0);
    checkOutput("idle_busy",     bus.busy,      0);
    checkOutput("idle_job_done", bus.job_done,  0);
    checkOutput("idle_start",    bus.tpu_start, 0);
    checkOutput("idle_owner",    bus.owner_id,  owner);
    modelPtr = (owner + 1) % NUM_REQ;
  endtask

  // Idle cycles with no request and a stray tpu_done: nothing may move.
  task automatic idleSpurious(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bus.tpu_done = 1'b1;
      step();
      checkOutput("spur_idle_busy", bus.busy,      0);
      checkOutput("spur_idle_start", bus.tpu_start, 0);
      checkOutput("spur_idle_done", bus.job_done,  0);
    end
    bus.tpu_done = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global time limit reached");
  end

  initial begin
    logic [NUM_REQ-1:0] newBits;
    int                 owner;
    logic [NUM_REQ-1:0] expGnt;

    bus.req_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) addrTab[i] = '0;
    applyReset();
    checkAllZero("reset");

    // Single request, tpu_done 10 cycles after tpu_start.
    addrTab[1] = 10'h055;
    packAddr();
    bus.req = 4'b0010;
    applyStimulus(10, 1'b0, 1'b0, 1);

    // All four requesting continuously: grant order 0,1,2,3,0.
    applyReset();
    addrTab[0] = 10'h100; addrTab[1] = 10'h201;
    addrTab[2] = 10'h302; addrTab[3] = 10'h3FF;
    packAddr();
    for (int j = 0; j < 5; j++) begin
      bus.req = 4'b1111;
      applyStimulus(3, 1'b0, 1'b0, j % NUM_REQ);
    end
    bus.req = '0;

    // Move the pointer to 3, then 1001 must grant 3 then 0.
    bus.req = 4'b0100;
    applyStimulus(2, 1'b0, 1'b0, 2);
    bus.req = 4'b1001;
    applyStimulus(2, 1'b0, 1'b0, 3);
    applyStimulus(2, 1'b0, 1'b0, 0);

    // req[2] dropped during RUN: job completes, no extra start afterwards.
    bus.req = 4'b0100;
    applyStimulus(4, 1'b0, 1'b1, 2);
    step();
    checkOutput("drop_no_restart", bus.tpu_start, 0);
    checkOutput("drop_idle_busy",  bus.busy,      0);

    // Spurious tpu_done in IDLE and in START.
    idleSpurious(3);
    bus.req = 4'b0001;
    applyStimulus(3, 1'b1, 1'b0, 0);

    // tpu_done withheld.
    bus.req = 4'b0010;
    owner   = rrPick(bus.req, modelPtr);
    expGnt  = '0;
    expGnt[owner] = 1'b1;
    noteGrant(owner);
    step();
    checkOutput("hold_start", bus.tpu_start, 1);
`ifdef SYS_ARB_TIMEOUT_EN
    for (int c = 1; c <= TIMEOUT; c++) begin
      step();
      checkOutput("wdog_wait_done", bus.job_done, 0);
    end
    step();
    checkOutput("wdog_job_done", bus.job_done, expGnt);
    checkOutput("wdog_job_err",  bus.job_err,  1);
    bus.req[owner] = 1'b0;
    step();
    checkOutput("wdog_idle_busy", bus.busy, 0);
    modelPtr = (owner + 1) % NUM_REQ;
    // tpu_done on the expiry cycle wins: no error flag.
    bus.req = 4'b0100;
    applyStimulus(TIMEOUT, 1'b0, 1'b0, 2);
    bus.req = 4'b1000;
    step();
    step();
    step();
`else
    for (int c = 1; c <= 40; c++) begin
      step();
      checkOutput("hold_no_done", bus.job_done, 0);
      checkOutput("hold_no_err",  bus.job_err,  0);
    end
    checkOutput("hold_busy", bus.busy, 1);
    checkOutput("hold_gnt",  bus.gnt,  expGnt);
`endif

    // Asynchronous reset in the middle of RUN clears outputs immediately.
    srstn = 1'b0;
    #1;
    checkAllZero("async_rst");
    bus.req = '0;
    step();
    srstn    = 1'b1;
    modelPtr = 0;
    for (int i = 0; i < NUM_REQ; i++) waitCnt[i] = 0;
    step();
    checkOutput("post_rst_idle", bus.busy, 0);

    // Randomized jobs against the model.
    for (int j = 0; j < 40; j++) begin
      newBits = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1)) & ~bus.req;
      if ((bus.req | newBits) == '0) begin
        idleSpurious($urandom_range(1, 3));
        newBits[$urandom_range(0, NUM_REQ - 1)] = 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (newBits[i]) addrTab[i] = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      end
      packAddr();
      bus.req = bus.req | newBits;
      applyStimulus($urandom_range(2, 6), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), -1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
